// File: rtl/rab_ar_port.sv
// Read-address port in front of one RAB lookup port: holds one AR, forwards it after
// translation or answers it locally with SLVERR beats. Optional macro: RAB_ERR_PATTERN_EN.
module rab_ar_port #(
    parameter int unsigned C_AXI_ID_WIDTH   = 8,
    parameter int unsigned C_AXI_DATA_WIDTH = 64
) (
    input  logic                        s_axi_aclk,
    input  logic                        s_axi_areset,
    input  logic [31:0]                 s_axi_araddr,
    input  logic [C_AXI_ID_WIDTH-1:0]   s_axi_arid,
    input  logic [7:0]                  s_axi_arlen,
    input  logic [2:0]                  s_axi_arsize,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [C_AXI_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [C_AXI_ID_WIDTH-1:0]   s_axi_rid,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rlast,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic [31:0]                 m_axi_araddr,
    output logic [C_AXI_ID_WIDTH-1:0]   m_axi_arid,
    output logic [7:0]                  m_axi_arlen,
    output logic [2:0]                  m_axi_arsize,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    input  logic [C_AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [C_AXI_ID_WIDTH-1:0]   m_axi_rid,
    input  logic [1:0]                  m_axi_rresp,
    input  logic                        m_axi_rlast,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready,
    output logic [31:0]                 rab_addr,
    output logic [C_AXI_ID_WIDTH-1:0]   rab_id,
    output logic [7:0]                  rab_len,
    output logic [2:0]                  rab_size,
    output logic                        rab_addr_valid,
    output logic                        rab_type,
    output logic                        rab_sent,
    input  logic [31:0]                 rab_out_addr,
    input  logic                        rab_accept,
    input  logic                        rab_drop
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StLookup = 2'd1;
    localparam logic [1:0] StFwd    = 2'd2;
    localparam logic [1:0] StErr    = 2'd3;

`ifdef RAB_ERR_PATTERN_EN
    localparam logic [C_AXI_DATA_WIDTH-1:0] ErrData = {(C_AXI_DATA_WIDTH/32){32'hBADCAB1E}};
`else
    localparam logic [C_AXI_DATA_WIDTH-1:0] ErrData = '0;
`endif

    logic [1:0]                state_q, state_d;
    logic [31:0]               addr_q, addr_d;
    logic [C_AXI_ID_WIDTH-1:0] id_q, id_d;
    logic [7:0]                len_q, len_d;
    logic [2:0]                size_q, size_d;
    logic [31:0]               out_addr_q, out_addr_d;
    logic [7:0]                beat_cnt_q, beat_cnt_d;
    logic                      m_burst_q, m_burst_d;
    logic                      err_active;

    // Error beats only once the downstream burst in flight has drained.
    assign err_active = (state_q == StErr) && !m_burst_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        id_d       = id_q;
        len_d      = len_q;
        size_d     = size_q;
        out_addr_d = out_addr_q;
        beat_cnt_d = beat_cnt_q;
        m_burst_d  = m_burst_q;

        if (m_axi_rvalid && m_axi_rready) begin
            m_burst_d = !m_axi_rlast;
        end

        case (state_q)
            StIdle: begin
                if (s_axi_arvalid) begin
                    addr_d  = s_axi_araddr;
                    id_d    = s_axi_arid;
                    len_d   = s_axi_arlen;
                    size_d  = s_axi_arsize;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                if (rab_accept) begin
                    out_addr_d = rab_out_addr;
                    state_d    = StFwd;
                end else if (rab_drop) begin
                    beat_cnt_d = len_q;
                    state_d    = StErr;
                end
            end
            StFwd: begin
                if (m_axi_arready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                if (err_active && s_axi_rready) begin
                    if (beat_cnt_q == 8'd0) begin
                        state_d = StIdle;
                    end else begin
                        beat_cnt_d = beat_cnt_q - 8'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            id_q       <= '0;
            len_q      <= '0;
            size_q     <= '0;
            out_addr_q <= '0;
            beat_cnt_q <= '0;
            m_burst_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            id_q       <= id_d;
            len_q      <= len_d;
            size_q     <= size_d;
            out_addr_q <= out_addr_d;
            beat_cnt_q <= beat_cnt_d;
            m_burst_q  <= m_burst_d;
        end
    end

    always_comb begin
        s_axi_arready  = (state_q == StIdle) && !s_axi_areset;
        rab_addr       = addr_q;
        rab_id         = id_q;
        rab_len        = len_q;
        rab_size       = size_q;
        rab_addr_valid = (state_q == StLookup);
        rab_type       = 1'b0;
        m_axi_araddr   = out_addr_q;
        m_axi_arid     = id_q;
        m_axi_arlen    = len_q;
        m_axi_arsize   = size_q;
        m_axi_arvalid  = (state_q == StFwd);
        rab_sent       = (state_q == StFwd) && m_axi_arready;

        if (err_active) begin
            s_axi_rdata  = ErrData;
            s_axi_rid    = id_q;
            s_axi_rresp  = 2'b10;
            s_axi_rlast  = (beat_cnt_q == 8'd0);
            s_axi_rvalid = 1'b1;
            m_axi_rready = 1'b0;
        end else begin
            s_axi_rdata  = m_axi_rdata;
            s_axi_rid    = m_axi_rid;
            s_axi_rresp  = m_axi_rresp;
            s_axi_rlast  = m_axi_rlast;
            s_axi_rvalid = m_axi_rvalid;
            m_axi_rready = s_axi_rready;
        end
    end

endmodule

// File: tb/tb_rab_ar_port.sv
// Directed bench for rab_ar_port: table of AR transactions plus hand-written corner sequences.
module tb_rab_ar_port;

    localparam int IW = 8;
    localparam int DW = 64;
`ifdef RAB_ERR_PATTERN_EN
    localparam logic [63:0] ERR_DATA = 64'hBADCAB1E_BADCAB1E;
`else
    localparam logic [63:0] ERR_DATA = 64'h0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   s_araddr;
    logic [IW-1:0] s_arid;
    logic [7:0]    s_arlen;
    logic [2:0]    s_arsize;
    logic          s_arvalid, s_arready;
    logic [DW-1:0] s_rdata;
    logic [IW-1:0] s_rid;
    logic [1:0]    s_rresp;
    logic          s_rlast, s_rvalid, s_rready;
    logic [31:0]   m_araddr;
    logic [IW-1:0] m_arid;
    logic [7:0]    m_arlen;
    logic [2:0]    m_arsize;
    logic          m_arvalid, m_arready;
    logic [DW-1:0] m_rdata;
    logic [IW-1:0] m_rid;
    logic [1:0]    m_rresp;
    logic          m_rlast, m_rvalid, m_rready;
    logic [31:0]   rab_addr;
    logic [IW-1:0] rab_id;
    logic [7:0]    rab_len;
    logic [2:0]    rab_size;
    logic          rab_addr_valid, rab_type, rab_sent;
    logic [31:0]   rab_out_addr;
    logic          rab_accept, rab_drop;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rab_ar_port #(.C_AXI_ID_WIDTH(IW), .C_AXI_DATA_WIDTH(DW)) dut (
        .s_axi_aclk(clk), .s_axi_areset(rst),
        .s_axi_araddr(s_araddr), .s_axi_arid(s_arid), .s_axi_arlen(s_arlen),
        .s_axi_arsize(s_arsize), .s_axi_arvalid(s_arvalid), .s_axi_arready(s_arready),
        .s_axi_rdata(s_rdata), .s_axi_rid(s_rid), .s_axi_rresp(s_rresp),
        .s_axi_rlast(s_rlast), .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready),
        .m_axi_araddr(m_araddr), .m_axi_arid(m_arid), .m_axi_arlen(m_arlen),
        .m_axi_arsize(m_arsize), .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
        .m_axi_rdata(m_rdata), .m_axi_rid(m_rid), .m_axi_rresp(m_rresp),
        .m_axi_rlast(m_rlast), .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready),
        .rab_addr(rab_addr), .rab_id(rab_id), .rab_len(rab_len), .rab_size(rab_size),
        .rab_addr_valid(rab_addr_valid), .rab_type(rab_type), .rab_sent(rab_sent),
        .rab_out_addr(rab_out_addr), .rab_accept(rab_accept), .rab_drop(rab_drop)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  id;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [31:0] out_addr;
        bit          drop;
        int          exp_beats;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic issue_ar(input vec_t v);
        @(negedge clk);
        s_arvalid = 1'b1; s_araddr = v.addr; s_arid = v.id; s_arlen = v.len; s_arsize = v.size;
        #1 chk("arready_idle", 64'(s_arready), 64'd1);
        @(negedge clk);
        s_arvalid = 1'b0; s_araddr = '0; s_arid = '0; s_arlen = '0; s_arsize = '0;
        #1;
        chk("arready_busy", 64'(s_arready), 64'd0);
        chk("rab_addr_valid", 64'(rab_addr_valid), 64'd1);
        chk("rab_addr", 64'(rab_addr), 64'(v.addr));
        chk("rab_id", 64'(rab_id), 64'(v.id));
        chk("rab_len", 64'(rab_len), 64'(v.len));
        chk("rab_size", 64'(rab_size), 64'(v.size));
        chk("rab_type", 64'(rab_type), 64'd0);
    endtask

    task automatic do_accept(input vec_t v, input int stall);
        int sent_seen;
        sent_seen = 0;
        @(negedge clk);
        rab_accept = 1'b1; rab_out_addr = v.out_addr;
        #1 chk("m_arvalid_in_lookup", 64'(m_arvalid), 64'd0);
        @(negedge clk);
        rab_accept = 1'b0; rab_out_addr = '0;
        #1;
        for (int c = 0; c <= stall; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #1;
            end
            chk("m_arvalid", 64'(m_arvalid), 64'd1);
            chk("m_araddr", 64'(m_araddr), 64'(v.out_addr));
            chk("m_arid", 64'(m_arid), 64'(v.id));
            chk("m_arlen", 64'(m_arlen), 64'(v.len));
            chk("m_arsize", 64'(m_arsize), 64'(v.size));
            chk("arready_fwd", 64'(s_arready), 64'd0);
            if (rab_sent) sent_seen++;
        end
        m_arready = 1'b1;
        #1;
        chk("rab_sent_hs", 64'(rab_sent), 64'd1);
        chk("arready_hs", 64'(s_arready), 64'd0);
        if (rab_sent) sent_seen++;
        @(negedge clk);
        m_arready = 1'b0;
        #1;
        if (rab_sent) sent_seen++;
        chk("rab_sent_count", 64'(sent_seen), 64'd1);
        chk("m_arvalid_after", 64'(m_arvalid), 64'd0);
        chk("arready_after", 64'(s_arready), 64'd1);
    endtask

    // Consumes exp_beats error beats with rready high from the first ERR cycle.
    task automatic err_beats(input logic [7:0] id, input int exp_beats);
        s_rready = 1'b1;
        for (int b = 0; b < exp_beats; b++) begin
            #1;
            chk("err_rvalid", 64'(s_rvalid), 64'd1);
            chk("err_rresp", 64'(s_rresp), 64'd2);
            chk("err_rid", 64'(s_rid), 64'(id));
            chk("err_rlast", 64'(s_rlast), 64'(b == exp_beats - 1));
            chk("err_rdata", 64'(s_rdata), ERR_DATA);
            chk("err_m_rready", 64'(m_rready), 64'd0);
            chk("err_m_arvalid", 64'(m_arvalid), 64'd0);
            @(negedge clk);
        end
        #1;
        chk("err_done_rvalid", 64'(s_rvalid), 64'd0);
        chk("err_done_arready", 64'(s_arready), 64'd1);
        s_rready = 1'b0;
    endtask

    task automatic do_drop(input vec_t v);
        @(negedge clk);
        rab_drop = 1'b1;
        @(negedge clk);
        rab_drop = 1'b0;
        err_beats(v.id, v.exp_beats);
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{32'h1000_0040, 8'h05, 8'd3,   3'd3, 32'h8000_0040, 1'b0, 0};
        vecs[1] = '{32'h2000_0000, 8'h11, 8'd3,   3'd2, 32'h0,         1'b1, 4};
        vecs[2] = '{32'hFFFF_FFFC, 8'hFF, 8'd0,   3'd2, 32'h0000_0004, 1'b0, 0};
        vecs[3] = '{32'h3000_0000, 8'h42, 8'd255, 3'd3, 32'h0,         1'b1, 256};
        vecs[4] = '{32'h4000_1000, 8'h00, 8'd0,   3'd0, 32'h0,         1'b1, 1};

        rst = 1'b1;
        s_araddr = '0; s_arid = '0; s_arlen = '0; s_arsize = '0; s_arvalid = 1'b0;
        s_rready = 1'b0; m_arready = 1'b0;
        m_rdata = '0; m_rid = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
        rab_out_addr = '0; rab_accept = 1'b0; rab_drop = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_arready", 64'(s_arready), 64'd0);
        chk("rst_rvalid", 64'(s_rvalid), 64'd0);
        chk("rst_m_arvalid", 64'(m_arvalid), 64'd0);
        chk("rst_rab_valid", 64'(rab_addr_valid), 64'd0);
        chk("rst_rab_sent", 64'(rab_sent), 64'd0);
        chk("rst_m_araddr", 64'(m_araddr), 64'd0);
        chk("rst_rab_id", 64'(rab_id), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_arready", 64'(s_arready), 64'd1);

        for (int i = 0; i < 5; i++) begin
            issue_ar(vecs[i]);
            if (vecs[i].drop) do_drop(vecs[i]);
            else do_accept(vecs[i], 0);
        end

        // Downstream stalls AR for 10 cycles.
        v = '{32'h5000_0080, 8'h21, 8'd7, 3'd3, 32'h9000_0080, 1'b0, 0};
        issue_ar(v);
        do_accept(v, 10);

        // Drop arrives while a len=7 downstream burst is at beat 2.
        v = '{32'h6000_0000, 8'h22, 8'd3, 3'd3, 32'h0, 1'b1, 4};
        issue_ar(v);
        s_rready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            m_rvalid = 1'b1; m_rid = 8'h07; m_rdata = 64'(b); m_rresp = 2'b00;
            m_rlast = (b == 7);
            rab_drop = (b == 1);
            #1;
            chk("pt_rvalid", 64'(s_rvalid), 64'd1);
            chk("pt_rdata", 64'(s_rdata), 64'(b));
            chk("pt_rid", 64'(s_rid), 64'h07);
            chk("pt_rresp", 64'(s_rresp), 64'd0);
            chk("pt_rlast", 64'(s_rlast), 64'(b == 7));
            chk("pt_m_rready", 64'(m_rready), 64'd1);
        end
        @(negedge clk);
        m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0; m_rid = '0; rab_drop = 1'b0;
        err_beats(8'h22, 4);

        // Reset asserted after 2 of 4 error beats.
        v = '{32'h7000_0000, 8'h33, 8'd3, 3'd3, 32'h0, 1'b1, 4};
        issue_ar(v);
        @(negedge clk);
        rab_drop = 1'b1;
        @(negedge clk);
        rab_drop = 1'b0;
        s_rready = 1'b1;
        repeat (2) @(negedge clk);
        #1 chk("pre_rst_rvalid", 64'(s_rvalid), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_rvalid", 64'(s_rvalid), 64'd0);
        chk("mid_rst_arready", 64'(s_arready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_rst_arready", 64'(s_arready), 64'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1 chk("no_leftover_rvalid", 64'(s_rvalid), 64'd0);
        end
        s_rready = 1'b0;

        // len=0 drop, upstream not ready for 5 cycles.
        v = '{32'h7100_0000, 8'h44, 8'd0, 3'd2, 32'h0, 1'b1, 1};
        issue_ar(v);
        @(negedge clk);
        rab_drop = 1'b1;
        @(negedge clk);
        rab_drop = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("hold_rvalid", 64'(s_rvalid), 64'd1);
            chk("hold_rlast", 64'(s_rlast), 64'd1);
            chk("hold_rdata", 64'(s_rdata), ERR_DATA);
            chk("hold_rid", 64'(s_rid), 64'h44);
            @(negedge clk);
        end
        err_beats(8'h44, 1);

        // Accept and drop in the same cycle: accept wins.
        v = '{32'h7200_0000, 8'h55, 8'd1, 3'd3, 32'hA200_0000, 1'b0, 0};
        issue_ar(v);
        @(negedge clk);
        rab_accept = 1'b1; rab_drop = 1'b1; rab_out_addr = v.out_addr;
        @(negedge clk);
        rab_accept = 1'b0; rab_drop = 1'b0; rab_out_addr = '0;
        #1;
        chk("both_m_arvalid", 64'(m_arvalid), 64'd1);
        chk("both_m_araddr", 64'(m_araddr), 64'hA200_0000);
        chk("both_rvalid", 64'(s_rvalid), 64'd0);
        m_arready = 1'b1;
        @(negedge clk);
        m_arready = 1'b0;
        #1 chk("both_idle", 64'(s_arready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rab_ar_port.md
Name: rab_ar_port

Overview:
- Slave-side read-address port that feeds one RAB lookup port (port1 or port2 of one RAB port index).
- Accepts AXI AR requests from an upstream master, holds each one, and presents it to the RAB.
- On accept: forwards the translated address downstream on the master AR channel and signals sent.
- On drop: generates the full SLVERR read response locally, merged into the R channel toward the master.

Parameters:
- C_AXI_ID_WIDTH, 8, AXI ID width.
- C_AXI_DATA_WIDTH, 64, R data width (multiple of 32).

Ports:
- s_axi_aclk  in  1  clock
- s_axi_areset  in  1  reset, asynchronous, active-high
- s_axi_ar{addr,id,len,size,valid}  in  32/ID/8/3/1  upstream AR
- s_axi_arready  out  1  upstream AR ready
- s_axi_r{data,id,resp,last,valid}  out  DATA/ID/2/1/1  upstream R
- s_axi_rready  in  1  upstream R ready
- m_axi_ar{addr,id,len,size,valid}  out  32/ID/8/3/1  downstream AR (translated)
- m_axi_arready  in  1  downstream AR ready
- m_axi_r{data,id,resp,last,valid}  in  DATA/ID/2/1/1  downstream R
- m_axi_rready  out  1  downstream R ready
- rab_addr, rab_id, rab_len, rab_size  out  32/ID/8/3  lookup request fields
- rab_addr_valid  out  1  lookup request valid
- rab_type  out  1  constant 0 (read)
- rab_sent  out  1  one-cycle pulse: translated AR handshaken downstream
- rab_out_addr  in  32  translated address, valid in the rab_accept cycle
- rab_accept, rab_drop  in  1  one-cycle lookup result pulses

Behaviour:
- Reset values: all valid outputs 0; s_axi_arready 0; rab_sent 0; data, addr and id outputs 0; FSM in IDLE.
- IDLE:
  - s_axi_arready=1.
  - On s_axi_arvalid&&arready, capture addr/id/len/size → LOOKUP.
  - s_axi_arready is 0 in every other state, so there is one outstanding request per instance.
- LOOKUP:
  - rab_addr_valid=1, and the rab_* fields come from the capture register and stay stable.
  - rab_accept: latch rab_out_addr → FWD.
  - rab_drop: load beat_cnt=len → ERR.
  - accept and drop together: accept wins; counts as a RAB fault, and the verification environment flags it.
- FWD:
  - m_axi_arvalid=1 with the translated address and the captured id/len/size.
  - Fields are held stable until m_axi_arready.
  - In the handshake cycle, rab_sent=1 for exactly one cycle → IDLE.
- ERR:
  - m_burst flag: set on m_axi_rvalid&&rready&&!rlast; cleared on the rlast handshake.
  - While m_burst=1, downstream R passes through and no error beat is emitted (no AXI4 interleave).
  - Once m_burst=0: m_axi_rready=0, s_axi_rvalid=1, rresp=2'b10, rid=captured id, rlast=(beat_cnt==0).
  - Each s_axi_rready beat decrements beat_cnt; the last handshake → IDLE.
  - len=0 gives a single beat with rlast=1.
  - len=255 gives 256 beats; the counter does not wrap.
- Outside ERR injection, R is a combinational pass-through: s_axi_r*=m_axi_r*, m_axi_rready=s_axi_rready.
- Latency:
  - IDLE→LOOKUP: 1 cycle after the AR handshake.
  - FWD: entered the cycle after accept.
  - Minimum AR-in to AR-out: 2 cycles plus RAB latency.
- Reset mid-operation: the captured request is discarded, any error burst is aborted, and all outputs return to reset values immediately.

Optional Feature:
- RAB_ERR_PATTERN_EN defined: error-beat rdata = 32'hBADCAB1E replicated across C_AXI_DATA_WIDTH.
- Undefined: error-beat rdata = 0.
- rresp, rid and rlast behaviour are identical in both cases.

Test Plan:
- AR addr=0x1000_0040, id=0x05, len=3, size=3; RAB accept with out_addr=0x8000_0040.
  - m_axi_araddr=0x8000_0040, len=3, id=0x05.
  - rab_sent is a one-cycle pulse in the handshake cycle; s_axi_arready=0 until the state after the handshake.
- AR id=0x11, len=3, RAB drop → exactly 4 upstream beats: rresp=2'b10, rid=0x11, rlast only on beat 4; no m_axi_arvalid.
- Drop while downstream len=7 burst is at beat 2 → 6 remaining passthrough beats first, then 4 error beats; no interleave.
- m_axi_arready held low 10 cycles in FWD → m_axi_ar* stable all 10 cycles; rab_sent exactly once.
- Reset asserted in ERR after beat 2 of 4 → s_axi_rvalid=0 immediately; after release, IDLE with s_axi_arready=1 and no leftover beats.
- len=0 drop with s_axi_rready=0 for 5 cycles → rvalid held with rlast=1; single beat; error-beat rdata checked in both builds (BADCAB1E pattern / 0).
